// File: rtl/hd44780_cmd_arbiter.sv
// hd44780_cmd_arbiter: shares the HD44780 command port between two sequencers, burst-granted with LCD execution delays
module hd44780_cmd_arbiter #(
    parameter logic [10:0] SHORT_WAIT = 11'd32,
    parameter logic [10:0] LONG_WAIT  = 11'd1224,
    parameter logic [2:0]  SLOW_SEL   = 3'b110
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ena,
    input  logic       i_req0,
    input  logic       i_last0,
    input  logic       i_data0,
    input  logic [2:0] i_sel0,
    input  logic [3:0] i_val0,
    output logic       o_ack0,
    input  logic       i_req1,
    input  logic       i_last1,
    input  logic       i_data1,
    input  logic [2:0] i_sel1,
    input  logic [3:0] i_val1,
    output logic       o_ack1,
    output logic       o_strobe,
    output logic       o_data,
    output logic [2:0] o_sel,
    output logic [3:0] o_val,
    output logic       o_gnt,
    output logic       o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [10:0] cnt_q, cnt_d;
    logic        strobe_q, strobe_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        data_q, data_d;
    logic [2:0]  sel_q, sel_d;
    logic [3:0]  val_q, val_d;
    logic        win, owner_req, issue, pay_data;
    logic [2:0]  pay_sel;
    assign o_strobe = strobe_q;
    assign o_ack0   = ack0_q;
    assign o_ack1   = ack1_q;
    assign o_data   = data_q;
    assign o_sel    = sel_q;
    assign o_val    = val_q;
    assign o_gnt    = gnt_q;
    assign o_busy   = state_q != IDLE;
    // State register; reset aborts any burst or wait at once
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end
    // Next state: bursts stay locked to the owner until last or an abandoned request
    always_comb begin
        win       = (i_req0 && i_req1) ? ~gnt_q : i_req1;
        owner_req = gnt_q ? i_req1 : i_req0;
        state_d   = state_q == IDLE  ? ((i_req0 || i_req1) ? ISSUE : IDLE) :
                    state_q == ISSUE ? WAIT :
                    state_q == WAIT  ? ((cnt_q != 11'd0) ? WAIT : (!last_q && owner_req) ? ISSUE : IDLE) :
                    IDLE;
    end
    // Output/datapath next values: payload, acks and delay counter load on entry to ISSUE
    always_comb begin
        issue    = state_d == ISSUE;
        gnt_d    = (issue && state_q == IDLE) ? win : gnt_q;
        pay_data = gnt_d ? i_data1 : i_data0;
        pay_sel  = gnt_d ? i_sel1 : i_sel0;
        strobe_d = issue;
        ack0_d   = issue && !gnt_d;
        ack1_d   = issue && gnt_d;
        data_d   = issue ? pay_data : data_q;
        sel_d    = issue ? pay_sel : sel_q;
        val_d    = issue ? (gnt_d ? i_val1 : i_val0) : val_q;
        last_d   = issue ? (gnt_d ? i_last1 : i_last0) : last_q;
        cnt_d    = issue ? ((!pay_data && pay_sel == SLOW_SEL) ? LONG_WAIT : SHORT_WAIT) :
                   (state_q == WAIT && i_ena && cnt_q != 11'd0) ? cnt_q - 11'd1 : cnt_q;
    end
    // Registered outputs and burst bookkeeping; o_gnt resets to 1 so port 0 wins the first tie
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            gnt_q    <= 1'b1;
            last_q   <= 1'b0;
            cnt_q    <= 11'd0;
            strobe_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            data_q   <= 1'b0;
            sel_q    <= 3'd0;
            val_q    <= 4'd0;
        end else begin
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            val_q    <= val_d;
        end
    end
endmodule

// File: tb/tb_hd44780_cmd_arbiter.sv
// tb_hd44780_cmd_arbiter: table-driven directed checks of the HD44780 command arbiter
module tb_hd44780_cmd_arbiter;
    logic       i_clk = 1'b0, i_reset_n = 1'b0, i_ena = 1'b0;
    logic       i_req0 = 1'b0, i_last0 = 1'b0, i_data0 = 1'b0;
    logic [2:0] i_sel0 = 3'd0;
    logic [3:0] i_val0 = 4'd0;
    logic       i_req1 = 1'b0, i_last1 = 1'b0, i_data1 = 1'b0;
    logic [2:0] i_sel1 = 3'd0;
    logic [3:0] i_val1 = 4'd0;
    logic       o_ack0, o_ack1, o_strobe, o_data, o_gnt, o_busy;
    logic [2:0] o_sel;
    logic [3:0] o_val;
    int tests = 0, fails = 0;
    always #5 i_clk = ~i_clk;
    hd44780_cmd_arbiter dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ena(i_ena),
        .i_req0(i_req0), .i_last0(i_last0), .i_data0(i_data0), .i_sel0(i_sel0), .i_val0(i_val0), .o_ack0(o_ack0),
        .i_req1(i_req1), .i_last1(i_last1), .i_data1(i_data1), .i_sel1(i_sel1), .i_val1(i_val1), .o_ack1(o_ack1),
        .o_strobe(o_strobe), .o_data(o_data), .o_sel(o_sel), .o_val(o_val), .o_gnt(o_gnt), .o_busy(o_busy)
    );
    typedef struct {
        logic       rst;
        logic       r0, l0, d0;
        logic [2:0] s0;
        logic [3:0] v0;
        logic       r1, l1, d1;
        logic [2:0] s1;
        logic [3:0] v1;
        logic       ena;
        int         n;
        logic [4:0] ctl;
        logic [7:0] pay;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(input logic rst, input logic r0, input logic l0, input logic d0,
                                input logic [2:0] s0, input logic [3:0] v0,
                                input logic r1, input logic l1, input logic d1,
                                input logic [2:0] s1, input logic [3:0] v1,
                                input logic ena, input int n, input logic [4:0] ctl, input logic [7:0] pay);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.l0 = l0; v.d0 = d0; v.s0 = s0; v.v0 = v0;
        v.r1 = r1; v.l1 = l1; v.d1 = d1; v.s1 = s1; v.v1 = v1;
        v.ena = ena; v.n = n; v.ctl = ctl; v.pay = pay;
        return v;
    endfunction
    function automatic logic [12:0] obs();
        return {o_strobe, o_ack0, o_ack1, o_gnt, o_busy, o_data, o_sel, o_val};
    endfunction
    task automatic chk(input string nm, input int idx, input logic [12:0] exp);
        logic [12:0] act;
        act = obs();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s #%0d: {stb,ack0,ack1,gnt,busy,data,sel,val} got %b expected %b", nm, idx, act, exp);
        end
    endtask
    task automatic do_reset();
        i_reset_n = 1'b0;
        {i_req0, i_last0, i_data0, i_sel0, i_val0, i_req1, i_last1, i_data1, i_sel1, i_val1, i_ena} = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask
    initial begin
        logic quiet;
        // ctl = {strobe, ack0, ack1, gnt, busy}; pay = {data, sel, val}
        // both request after reset: port 0, then port 1, then port 0
        tbl.push_back(mk(1, 1,1,1,3'd0,4'd1, 1,1,1,3'd0,4'd2, 0,1,  5'b11001, 8'h81));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd1, 1,1,1,3'd0,4'd2, 1,33, 5'b00001, 8'h81));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd1, 1,1,1,3'd0,4'd2, 0,1,  5'b00000, 8'h81));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd1, 1,1,1,3'd0,4'd2, 0,1,  5'b10111, 8'h82));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd1, 1,1,1,3'd0,4'd2, 1,33, 5'b00011, 8'h82));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd1, 1,1,1,3'd0,4'd2, 0,1,  5'b00010, 8'h82));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd1, 1,1,1,3'd0,4'd2, 0,1,  5'b11001, 8'h81));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 1,33, 5'b00001, 8'h81));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 0,1,  5'b00000, 8'h81));
        // single beat, short wait; ena during ISSUE is ignored; port 1 waits out 32 ticks
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd5, 0,0,0,3'd0,4'd0, 0,1,  5'b11001, 8'h85));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 1,1,  5'b00001, 8'h85));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,1,1,3'd0,4'd9, 1,32, 5'b00001, 8'h85));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,1,1,3'd0,4'd9, 0,1,  5'b00000, 8'h85));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,1,1,3'd0,4'd9, 0,1,  5'b10111, 8'h89));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 1,33, 5'b00011, 8'h89));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 0,1,  5'b00010, 8'h89));
        // slow command: queued second beat only after 1224 ticks
        tbl.push_back(mk(0, 1,0,0,3'd6,4'd0, 0,0,0,3'd0,4'd0, 0,1,    5'b11001, 8'h60));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd3, 0,0,0,3'd0,4'd0, 1,1224, 5'b00001, 8'h60));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd3, 0,0,0,3'd0,4'd0, 1,1,    5'b00001, 8'h60));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd3, 0,0,0,3'd0,4'd0, 0,1,    5'b11001, 8'h83));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 1,33,   5'b00001, 8'h83));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 0,1,    5'b00000, 8'h83));
        // sel=110 with data=1 is a normal command: short wait
        tbl.push_back(mk(0, 1,1,1,3'd6,4'd0, 0,0,0,3'd0,4'd0, 0,1,  5'b11001, 8'hE0));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 1,33, 5'b00001, 8'hE0));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 0,1,  5'b00000, 8'hE0));
        // port 0 four-beat burst is locked against port 1
        tbl.push_back(mk(0, 1,0,1,3'd0,4'd1, 0,0,0,3'd0,4'd0, 0,1,  5'b11001, 8'h81));
        tbl.push_back(mk(0, 1,0,1,3'd0,4'd2, 1,1,1,3'd0,4'd7, 1,33, 5'b00001, 8'h81));
        tbl.push_back(mk(0, 1,0,1,3'd0,4'd2, 1,1,1,3'd0,4'd7, 0,1,  5'b11001, 8'h82));
        tbl.push_back(mk(0, 1,0,1,3'd0,4'd3, 1,1,1,3'd0,4'd7, 1,33, 5'b00001, 8'h82));
        tbl.push_back(mk(0, 1,0,1,3'd0,4'd3, 1,1,1,3'd0,4'd7, 0,1,  5'b11001, 8'h83));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd4, 1,1,1,3'd0,4'd7, 1,33, 5'b00001, 8'h83));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd4, 1,1,1,3'd0,4'd7, 0,1,  5'b11001, 8'h84));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,1,1,3'd0,4'd7, 1,33, 5'b00001, 8'h84));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,1,1,3'd0,4'd7, 0,1,  5'b00000, 8'h84));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,1,1,3'd0,4'd7, 0,1,  5'b10111, 8'h87));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 1,33, 5'b00011, 8'h87));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 0,1,  5'b00010, 8'h87));
        // port 1 abandons its burst; port 0 then served
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,0,0,3'd0,4'd1, 0,1,  5'b10111, 8'h01));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,0,0,3'd0,4'd2, 1,33, 5'b00011, 8'h01));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 1,0,0,3'd0,4'd2, 0,1,  5'b10111, 8'h02));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd6, 0,0,0,3'd0,4'd0, 1,33, 5'b00011, 8'h02));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd6, 0,0,0,3'd0,4'd0, 0,1,  5'b00010, 8'h02));
        tbl.push_back(mk(0, 1,1,1,3'd0,4'd6, 0,0,0,3'd0,4'd0, 0,1,  5'b11001, 8'h86));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 1,33, 5'b00001, 8'h86));
        tbl.push_back(mk(0, 0,0,0,3'd0,4'd0, 0,0,0,3'd0,4'd0, 0,1,  5'b00000, 8'h86));
        do_reset();
        chk("reset", 0, {5'b00010, 8'h00});
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            {i_req0, i_last0, i_data0, i_sel0, i_val0} = {tbl[i].r0, tbl[i].l0, tbl[i].d0, tbl[i].s0, tbl[i].v0};
            {i_req1, i_last1, i_data1, i_sel1, i_val1} = {tbl[i].r1, tbl[i].l1, tbl[i].d1, tbl[i].s1, tbl[i].v1};
            i_ena = tbl[i].ena;
            quiet = 1'b1;
            for (int c = 0; c < tbl[i].n; c++) begin
                @(posedge i_clk);
                #1;
                if (c < tbl[i].n - 1 && (o_strobe || o_ack0 || o_ack1)) quiet = 1'b0;
            end
            if (tbl[i].n > 1) begin
                tests++;
                if (!quiet) begin
                    fails++;
                    $display("FAIL quiet #%0d: strobe/ack seen during wait, got active expected none", i);
                end
            end
            chk("vec", i, {tbl[i].ctl, tbl[i].pay});
        end
        // reset during a long wait, then port 1 served one cycle after its request is sampled
        {i_req0, i_last0, i_data0, i_sel0, i_val0} = {1'b1, 1'b1, 1'b0, 3'd6, 4'd0};
        i_ena = 1'b0;
        step(1);
        chk("rst_issue", 0, {5'b11001, 8'h60});
        i_req0 = 1'b0;
        i_ena = 1'b1;
        step(11);
        chk("rst_wait", 0, {5'b00001, 8'h60});
        #2 i_reset_n = 1'b0;
        i_ena = 1'b0;
        #1 chk("rst_abort", 0, {5'b00010, 8'h00});
        @(negedge i_clk);
        i_reset_n = 1'b1;
        {i_req1, i_last1, i_data1, i_sel1, i_val1} = {1'b1, 1'b1, 1'b1, 3'd0, 4'd4};
        #1 chk("rst_idle", 0, {5'b00010, 8'h00});
        step(1);
        chk("rst_req1", 0, {5'b10111, 8'h84});
        i_req1 = 1'b0;
        i_ena = 1'b1;
        step(33);
        chk("rst_wait1", 0, {5'b00011, 8'h84});
        i_ena = 1'b0;
        step(1);
        chk("rst_done", 0, {5'b00010, 8'h84});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
